axi_rd_burst_master: RTL and testbench



---
 rtl/axi_rd_burst_master_pkg.sv | 35 +++
 rtl/axi_rd_extract.sv | 33 +++
 rtl/axi_rd_burst_master.sv | 216 +++++++++++++++++++++
 tb/tb_axi_rd_burst_master.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_burst_master_pkg.sv
// Shared AXI read-master definitions: protocol constants, FSM state encoding
// and the byte-size mask helper used by the narrow-read extractor.
package axi_rd_burst_master_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int MAX_DATA_W = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Low 8*2^size bits set, clamped to the bus width; callers cast to their width.
    function automatic logic [MAX_DATA_W-1:0] size_mask(input logic [2:0] size, input int data_w);
        logic [MAX_DATA_W-1:0] mask;
        int                    bits;
        bits = int'(32'd8 << size);
        bits = (bits > data_w) ? data_w : bits;
        for (int i = 32'sd0; i < MAX_DATA_W; i++) begin
            mask[i] = (i < bits);
        end
        return mask;
    endfunction

endpackage

// File: rtl/axi_rd_extract.sv
// Narrow-word extractor: shifts the addressed bytes of a bus beat down to bit 0,
// masks to the access size and flags accesses that run past the bus boundary.
module axi_rd_extract
    import axi_rd_burst_master_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [OFF_W-1:0]  offset,
    input  logic [2:0]        size,
    output logic [DATA_W-1:0] word,
    output logic              overflow
);

    localparam logic [8:0] BUS_BYTES = 9'(DATA_W / 8);

    logic [DATA_W-1:0] shifted_s;
    logic [8:0]        raw_bytes_s;
    logic [8:0]        bytes_s;
    logic [9:0]        end_s;

    // Byte-lane shift, size mask and boundary check
    always_comb begin
        shifted_s   = rdata >> {offset, 3'b000};
        word        = shifted_s & DATA_W'(size_mask(size, DATA_W));
        raw_bytes_s = 9'd1 << size;
        bytes_s     = (raw_bytes_s > BUS_BYTES) ? BUS_BYTES : raw_bytes_s;
        end_s       = {1'b0, bytes_s} + 10'(offset);
        overflow    = (end_s > {1'b0, BUS_BYTES});
    end

endmodule

// File: rtl/axi_rd_burst_master.sv
// AXI4 read master: one request at a time, single narrow read or INCR burst,
// beats gathered into a line buffer and returned with a merged response.
module axi_rd_burst_master
    import axi_rd_burst_master_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 64,
    parameter int ID_W      = 4,
    parameter int MAX_BEATS = 8,
    parameter int LEN_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [LEN_W-1:0]            req_len,
    input  logic [2:0]                  req_size,
    input  logic [ID_W-1:0]             req_id,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [MAX_BEATS*DATA_W-1:0] rsp_data,
    output logic [1:0]                  rsp_resp,
    output logic                        rsp_proto_err,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    output logic [ID_W-1:0]             m_arid,
    output logic [ADDR_W-1:0]           m_araddr,
    output logic [7:0]                  m_arlen,
    output logic [2:0]                  m_arsize,
    output logic [1:0]                  m_arburst,
    output logic [2:0]                  m_arprot,
    output logic [3:0]                  m_arcache,
    input  logic                        m_rvalid,
    output logic                        m_rready,
    input  logic [ID_W-1:0]             m_rid,
    input  logic [DATA_W-1:0]           m_rdata,
    input  logic [1:0]                  m_rresp,
    input  logic                        m_rlast
);

    localparam int         OFF_W    = $clog2(DATA_W / 8);
    localparam int         BUF_W    = MAX_BEATS * DATA_W;
    localparam logic [2:0] BUS_SIZE = 3'($clog2(DATA_W / 8));

    state_e                state_r;
    state_e                state_nxt_s;

    logic [OFF_W-1:0]      off_r;
    logic [LEN_W-1:0]      len_r;
    logic [2:0]            size_r;
    logic [ID_W-1:0]       id_r;
    logic [LEN_W-1:0]      beat_cnt_r;
    logic [BUF_W-1:0]      buf_r;
    logic [1:0]            resp_acc_r;

    logic                  req_ready_r;
    logic                  m_arvalid_r;
    logic                  m_rready_r;
    logic                  rsp_valid_r;
    logic [1:0]            rsp_resp_r;
    logic                  rsp_proto_err_r;
    logic [ID_W-1:0]       m_arid_r;
    logic [ADDR_W-1:0]     m_araddr_r;
    logic [7:0]            m_arlen_r;
    logic [2:0]            m_arsize_r;
    logic [1:0]            m_arburst_r;

    logic                  accept_s;
    logic                  ar_hs_s;
    logic                  r_hs_s;
    logic                  single_s;
    logic                  last_slot_s;
    logic                  beat_err_s;
    logic                  err_nxt_s;
    logic [1:0]            resp_nxt_s;
    logic [1:0]            resp_fin_s;
    logic [DATA_W-1:0]     beat_word_s;
    logic [DATA_W-1:0]     ext_word_s;
    logic                  ext_ovf_s;

    axi_rd_extract #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_extract (
        .rdata    (m_rdata),
        .offset   (off_r),
        .size     (size_r),
        .word     (ext_word_s),
        .overflow (ext_ovf_s)
    );

    assign accept_s = req_valid && req_ready_r;
    assign ar_hs_s  = m_arvalid_r && m_arready;
    assign r_hs_s   = m_rvalid && m_rready_r;

    // Per-beat classification, response merge and protocol checks
    always_comb begin
        single_s    = (len_r == {LEN_W{1'b0}});
        last_slot_s = (beat_cnt_r == len_r);
        beat_word_s = single_s ? ext_word_s : m_rdata;
        beat_err_s  = (m_rid != id_r)
                   || (m_rlast && !last_slot_s)
                   || (!m_rlast && last_slot_s)
                   || (single_s && ext_ovf_s);
        err_nxt_s   = rsp_proto_err_r || beat_err_s;
        resp_nxt_s  = (m_rresp > resp_acc_r) ? m_rresp : resp_acc_r;
        // A protocol fault must never be reported as a clean OKAY.
        resp_fin_s  = (err_nxt_s && (resp_nxt_s == RESP_OKAY)) ? RESP_SLVERR : resp_nxt_s;
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_ADDR;
                else          state_nxt_s = ST_IDLE;
            end
            ST_ADDR: begin
                if (ar_hs_s) state_nxt_s = ST_DATA;
                else         state_nxt_s = ST_ADDR;
            end
            ST_DATA: begin
                if (r_hs_s && (m_rlast || last_slot_s)) state_nxt_s = ST_RESP;
                else                                    state_nxt_s = ST_DATA;
            end
            ST_RESP: begin
                if (rsp_ready) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_RESP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and registered handshake outputs decoded from next state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b1;
            m_arvalid_r <= 1'b0;
            m_rready_r  <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            req_ready_r <= (state_nxt_s == ST_IDLE);
            m_arvalid_r <= (state_nxt_s == ST_ADDR);
            m_rready_r  <= (state_nxt_s == ST_DATA);
            rsp_valid_r <= (state_nxt_s == ST_RESP);
        end
    end

    // Request latch and AR channel fields, held until the next acceptance
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            off_r       <= {OFF_W{1'b0}};
            len_r       <= {LEN_W{1'b0}};
            size_r      <= 3'b000;
            id_r        <= {ID_W{1'b0}};
            m_arid_r    <= {ID_W{1'b0}};
            m_araddr_r  <= {ADDR_W{1'b0}};
            m_arlen_r   <= 8'h00;
            m_arsize_r  <= 3'b000;
            m_arburst_r <= 2'b00;
        end else if (accept_s) begin
            off_r       <= req_addr[OFF_W-1:0];
            len_r       <= req_len;
            size_r      <= req_size;
            id_r        <= req_id;
            m_arid_r    <= req_id;
            m_araddr_r  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            m_arlen_r   <= 8'(req_len);
            m_arsize_r  <= (req_len == {LEN_W{1'b0}}) ? req_size : BUS_SIZE;
            m_arburst_r <= BURST_INCR;
        end
    end

    // Line buffer, beat counter and accumulated response/error
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            beat_cnt_r      <= {LEN_W{1'b0}};
            buf_r           <= {BUF_W{1'b0}};
            resp_acc_r      <= RESP_OKAY;
            rsp_resp_r      <= RESP_OKAY;
            rsp_proto_err_r <= 1'b0;
        end else if (accept_s) begin
            beat_cnt_r      <= {LEN_W{1'b0}};
            buf_r           <= {BUF_W{1'b0}};
            resp_acc_r      <= RESP_OKAY;
            rsp_resp_r      <= RESP_OKAY;
            rsp_proto_err_r <= 1'b0;
        end else if (r_hs_s) begin
            buf_r[int'(beat_cnt_r) * DATA_W +: DATA_W] <= beat_word_s;
            beat_cnt_r      <= beat_cnt_r + LEN_W'(1);
            resp_acc_r      <= resp_nxt_s;
            rsp_resp_r      <= resp_fin_s;
            rsp_proto_err_r <= err_nxt_s;
        end
    end

    assign req_ready     = req_ready_r;
    assign m_arvalid     = m_arvalid_r;
    assign m_rready      = m_rready_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_data      = buf_r;
    assign rsp_resp      = rsp_resp_r;
    assign rsp_proto_err = rsp_proto_err_r;
    assign m_arid        = m_arid_r;
    assign m_araddr      = m_araddr_r;
    assign m_arlen       = m_arlen_r;
    assign m_arsize      = m_arsize_r;
    assign m_arburst     = m_arburst_r;
    assign m_arprot      = 3'b000;
    assign m_arcache     = 4'b0000;

endmodule

// File: tb/tb_axi_rd_burst_master.sv
// Self-checking bench for axi_rd_burst_master: vector table driven through a
// behavioural AXI slave, scoreboard of expected responses, plus reset sequences.
module tb_axi_rd_burst_master;

    localparam int DATA_W    = 64;
    localparam int ADDR_W    = 64;
    localparam int ID_W      = 4;
    localparam int MAX_BEATS = 8;
    localparam int LEN_W     = 3;
    localparam int NVEC      = 10;

    logic                        clk = 1'b0;
    logic                        reset_n = 1'b0;
    logic                        req_valid = 1'b0;
    logic                        req_ready;
    logic [ADDR_W-1:0]           req_addr = '0;
    logic [LEN_W-1:0]            req_len = '0;
    logic [2:0]                  req_size = '0;
    logic [ID_W-1:0]             req_id = '0;
    logic                        rsp_valid;
    logic                        rsp_ready = 1'b0;
    logic [MAX_BEATS*DATA_W-1:0] rsp_data;
    logic [1:0]                  rsp_resp;
    logic                        rsp_proto_err;
    logic                        m_arvalid;
    logic                        m_arready = 1'b0;
    logic [ID_W-1:0]             m_arid;
    logic [ADDR_W-1:0]           m_araddr;
    logic [7:0]                  m_arlen;
    logic [2:0]                  m_arsize;
    logic [1:0]                  m_arburst;
    logic [2:0]                  m_arprot;
    logic [3:0]                  m_arcache;
    logic                        m_rvalid = 1'b0;
    logic                        m_rready;
    logic [ID_W-1:0]             m_rid = '0;
    logic [DATA_W-1:0]           m_rdata = '0;
    logic [1:0]                  m_rresp = '0;
    logic                        m_rlast = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [63:0] addr;
        logic [2:0]  len;
        logic [2:0]  size;
        logic [3:0]  id;
        logic [3:0]  rid;
        logic [63:0] data0;
        int          last_beat;
        logic [15:0] resp_pat;
        int          ar_delay;
        int          hold;
        logic        rt;
        logic [1:0]  exp_resp;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [511:0] data;
        logic [1:0]   resp;
        logic         err;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t sb[$];

    axi_rd_burst_master #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .MAX_BEATS(MAX_BEATS), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_len(req_len), .req_size(req_size), .req_id(req_id),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp), .rsp_proto_err(rsp_proto_err),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arprot(m_arprot), .m_arcache(m_arcache),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Byte-by-byte reference for the returned line.
    function automatic logic [511:0] model_data(input vec_t v);
        logic [511:0] d;
        logic [63:0]  w;
        int accepted, nb, off;
        d = '0;
        w = '0;
        accepted = (v.last_beat < int'(v.len)) ? v.last_beat + 1 : int'(v.len) + 1;
        if (v.len == 3'd0) begin
            nb  = 1 << v.size;
            nb  = (nb > 8) ? 8 : nb;
            off = int'(v.addr[2:0]);
            for (int i = 0; i < nb; i++)
                if (off + i < 8) w[8*i +: 8] = v.data0[8*(off+i) +: 8];
            d[63:0] = w;
        end else begin
            for (int k = 0; k < accepted; k++) d[64*k +: 64] = v.data0 + 64'(k);
        end
        return d;
    endfunction

    task automatic run_txn(input vec_t v);
        exp_t         e;
        logic [63:0]  exp_araddr;
        logic [2:0]   exp_arsize;
        logic [511:0] d0;
        logic         stable;
        int           k, t_acc, guard;

        e.data = model_data(v);
        e.resp = v.exp_resp;
        e.err  = v.exp_err;
        sb.push_back(e);
        exp_araddr = {v.addr[63:3], 3'b000};
        exp_arsize = (v.len == 3'd0) ? v.size : 3'd3;

        @(negedge clk);
        req_addr = v.addr; req_len = v.len; req_size = v.size; req_id = v.id; req_valid = 1'b1;
        check("req_ready_idle", req_ready, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        t_acc = cyc;

        @(negedge clk);
        stable = 1'b1;
        for (int i = 0; i < v.ar_delay; i++) begin
            if (!(m_arvalid && m_araddr == exp_araddr && m_arlen == 8'(v.len) &&
                  m_arsize == exp_arsize && m_arid == v.id && !req_ready)) stable = 1'b0;
            @(negedge clk);
        end
        if (v.ar_delay > 0) check("ar_stable", stable, 1'b1);
        check("arvalid", m_arvalid, 1'b1);
        check("araddr", m_araddr, exp_araddr);
        check("arlen_arsize", {m_arlen, m_arsize}, {8'(v.len), exp_arsize});
        check("arid_burst_prot_cache", {m_arid, m_arburst, m_arprot, m_arcache}, {v.id, 2'b01, 3'b000, 4'b0000});
        m_arready = 1'b1;
        @(posedge clk);
        #1 m_arready = 1'b0;

        k = 0;
        forever begin
            @(negedge clk);
            m_rvalid = 1'b1;
            m_rdata  = v.data0 + 64'(k);
            m_rresp  = v.resp_pat[2*k +: 2];
            m_rid    = v.rid;
            m_rlast  = (k == v.last_beat);
            guard = 0;
            while (!m_rready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (!m_rready) begin
                check("rready_timeout", m_rready, 1'b1);
                m_rvalid = 1'b0;
                return;
            end
            @(posedge clk);
            #1 k++;
            if (k > v.last_beat || !m_rready) break;
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        check("rsp_valid_after_last_beat", rsp_valid, 1'b1);
        // Request in cycle 0, AR in cycle 1, R in cycle 2, rsp_valid in cycle 3.
        if (v.rt) check("round_trip_edges", 32'(cyc - t_acc), 32'd2);

        d0 = rsp_data;
        stable = 1'b1;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== d0 || req_ready) stable = 1'b0;
        end
        if (v.hold > 0) check("rsp_hold", stable, 1'b1);

        @(negedge clk);
        e = sb.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_resp", rsp_resp, e.resp);
        check("rsp_proto_err", rsp_proto_err, e.err);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("back_to_idle", {req_ready, rsp_valid}, 2'b10);
    endtask

    initial begin
        //            addr            len   size  id     rid    data0                   last pat      ard hold rt  resp   err
        vecs[0] = '{64'h8000_0005, 3'd0, 3'd0, 4'd3,  4'd3,  64'h1122334455667788, 0, 16'h0000, 0, 0, 1'b1, 2'b00, 1'b0};
        vecs[1] = '{64'h8000_0040, 3'd7, 3'd3, 4'd1,  4'd1,  64'h0,                7, 16'h0000, 3, 5, 1'b0, 2'b00, 1'b0};
        vecs[2] = '{64'h0000_1000, 3'd3, 3'd3, 4'd6,  4'd6,  64'h100,              3, 16'h00C8, 0, 0, 1'b0, 2'b11, 1'b0};
        vecs[3] = '{64'h0000_2000, 3'd3, 3'd3, 4'd4,  4'd4,  64'hA0,               1, 16'h0000, 0, 0, 1'b0, 2'b10, 1'b1};
        vecs[4] = '{64'h0000_3000, 3'd1, 3'd3, 4'd3,  4'd5,  64'hB0,               1, 16'h0000, 1, 0, 1'b0, 2'b10, 1'b1};
        vecs[5] = '{64'h0000_4000, 3'd1, 3'd3, 4'd7,  4'd7,  64'hC0,               3, 16'h0000, 0, 0, 1'b0, 2'b10, 1'b1};
        vecs[6] = '{64'h8000_0006, 3'd0, 3'd2, 4'd2,  4'd2,  64'h1122334455667788, 0, 16'h0000, 0, 0, 1'b0, 2'b10, 1'b1};
        vecs[7] = '{64'h0000_5000, 3'd0, 3'd7, 4'd1,  4'd1,  64'hCAFEF00D12345678, 0, 16'h0001, 0, 0, 1'b0, 2'b01, 1'b0};
        vecs[8] = '{64'h0000_6002, 3'd0, 3'd1, 4'd9,  4'd9,  64'h0011223344556677, 0, 16'h0002, 2, 0, 1'b0, 2'b10, 1'b0};
        vecs[9] = '{64'h0000_7000, 3'd1, 3'd3, 4'd2,  4'd2,  64'hE0,               0, 16'h0001, 0, 0, 1'b0, 2'b01, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_handshakes", {m_arvalid, m_rready, rsp_valid, rsp_proto_err, rsp_resp}, 6'b0);
        check("reset_ar_fields", {m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_arprot, m_arcache}, '0);
        check("reset_rsp_data", rsp_data, '0);
        check("reset_req_ready", req_ready, 1'b1);
        reset_n = 1'b1;

        // Known-answer check of the narrow extraction ahead of the table.
        run_txn(vecs[0]);
        check("single_known_answer", rsp_data[63:0], 64'h33);

        for (int i = 1; i < NVEC; i++) run_txn(vecs[i]);

        // Reset during DATA abandons the transaction.
        @(negedge clk);
        req_addr = 64'h9000; req_len = 3'd3; req_size = 3'd3; req_id = 4'd2; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        m_arready = 1'b1;
        @(posedge clk);
        #1 m_arready = 1'b0;
        @(negedge clk);
        m_rvalid = 1'b1; m_rdata = 64'hDEAD; m_rid = 4'd2; m_rresp = 2'b10; m_rlast = 1'b0;
        @(posedge clk);
        #1 m_rvalid = 1'b0;
        @(negedge clk);
        check("mid_data_rready", m_rready, 1'b1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_handshakes", {m_rready, m_arvalid, rsp_valid, rsp_proto_err, rsp_resp}, 6'b0);
        check("rst_mid_req_ready", req_ready, 1'b1);
        check("rst_mid_rsp_data", rsp_data, '0);
        check("rst_mid_ar_fields", {m_araddr, m_arlen, m_arsize, m_arburst, m_arid}, '0);
        @(negedge clk);
        reset_n = 1'b1;

        run_txn(vecs[2]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
